// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding and default geometry for the data-memory dump reader
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    localparam int DMEM_ADDR_W = 9;
    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_STEP   = 4;
endpackage

// File: rtl/rd_buf_fifo.sv
// rd_buf_fifo: small synchronous FIFO with occupancy count and same-cycle push/pop
module rd_buf_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_dout,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_cnt;
    logic w_push, w_pop;
    assign o_count = r_cnt;
    assign o_full  = r_cnt == CW'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_dout  = r_mem[r_rp];
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= i_din;
                r_wp        <= r_wp == PW'(DEPTH - 1) ? '0 : r_wp + PW'(1);
            end
            if (w_pop) r_rp <= r_rp == PW'(DEPTH - 1) ? '0 : r_rp + PW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end
    assert property (@(posedge clk) disable iff (rst) !(i_push && o_full && !i_pop));
endmodule

// File: rtl/dmem_dump_reader.sv
// dmem_dump_reader: walks a data-memory address range and streams each word out on valid/ready
module dmem_dump_reader
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = DMEM_ADDR_W,
    parameter int DATA_WIDTH = DMEM_DATA_W,
    parameter int ADDR_STEP  = DMEM_STEP,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_word_count,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_mem_re,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic [ADDR_WIDTH-1:0] o_out_addr
);
    localparam int BUF_DEPTH = RD_LATENCY + 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int FW = ADDR_WIDTH + DATA_WIDTH;
    state_t r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0] r_count, r_issued;
    logic [RD_LATENCY-1:0] r_tag_v;
    logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0] r_tag_a;
    logic [FW-1:0] w_head;
    logic [CW-1:0] w_occ;
    logic w_full, w_empty, w_pop, w_issue, w_drain;
    int w_used;
    // Slots committed to in-flight reads or buffered words; the word leaving this cycle frees its slot.
    always_comb begin
        w_used = int'(w_occ) - int'(w_pop);
        for (int i = 0; i < RD_LATENCY; i++) w_used += int'(r_tag_v[i]);
    end
    assign w_pop   = o_out_valid && i_out_ready;
    assign w_issue = r_state == RUN && r_issued != r_count && w_used < BUF_DEPTH;
    assign w_drain = r_issued == r_count && w_used == 0;
    always_comb begin
        w_next = r_state == IDLE ? (i_start ? (i_word_count == '0 ? FIN : RUN) : IDLE) :
                 r_state == RUN  ? (w_drain ? FIN : RUN) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_count  <= '0;
            r_issued <= '0;
            r_tag_v  <= '0;
            r_tag_a  <= '0;
        end else begin
            if (r_state == IDLE && i_start) begin
                r_addr   <= i_base_addr;
                r_count  <= i_word_count;
                r_issued <= '0;
            end else if (w_issue) begin
                r_addr   <= r_addr + ADDR_WIDTH'(ADDR_STEP);
                r_issued <= r_issued + (ADDR_WIDTH + 1)'(1);
            end
            r_tag_v[0] <= w_issue;
            r_tag_a[0] <= r_addr;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag_a[i] <= r_tag_a[i-1];
            end
        end
    end
    rd_buf_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(FW)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_tag_v[RD_LATENCY-1]),
        .i_din   ({r_tag_a[RD_LATENCY-1], i_mem_rdata}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_count (w_occ),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
    assign o_busy      = r_state != IDLE;
    assign o_done      = r_state == FIN;
    assign o_mem_re    = w_issue;
    assign o_mem_addr  = w_issue ? r_addr : '0;
    assign o_out_valid = !w_empty;
    assign o_out_data  = o_out_valid ? w_head[DATA_WIDTH-1:0] : '0;
    assign o_out_addr  = o_out_valid ? w_head[FW-1:DATA_WIDTH] : '0;
    assert property (@(posedge clk) disable iff (rst) w_full |-> (!w_issue || w_pop));
endmodule
